// File: rtl/mux2_rr_arbiter_if.sv
// Stream bundle between two packet sources, the round-robin arbiter and
// one consumer. The master modport is the arbiter's view; the slave
// modport is the view of the surrounding sources/consumer.
interface mux2_rr_arbiter_if #(
   parameter int SIZE = 8
);
   logic            A_VALID;
   logic [SIZE-1:0] A_DATA;
   logic            A_LAST;
   logic            A_READY;
   logic            B_VALID;
   logic [SIZE-1:0] B_DATA;
   logic            B_LAST;
   logic            B_READY;
   logic            OUT_VALID;
   logic [SIZE-1:0] OUT_DATA;
   logic            OUT_LAST;
   logic            OUT_READY;
   logic            SEL;
   logic            BUSY;

   modport master (
      input  A_VALID, A_DATA, A_LAST, B_VALID, B_DATA, B_LAST, OUT_READY,
      output A_READY, B_READY, OUT_VALID, OUT_DATA, OUT_LAST, SEL, BUSY
   );

   modport slave (
      output A_VALID, A_DATA, A_LAST, B_VALID, B_DATA, B_LAST, OUT_READY,
      input  A_READY, B_READY, OUT_VALID, OUT_DATA, OUT_LAST, SEL, BUSY
   );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Packet-atomic round-robin arbiter sharing one stream channel between
// requesters A and B. SEL is registered with the grant state and drives a
// plain 2:1 data mux. Optional macro MUX2_ARB_STATS_EN adds saturating
// per-source completed-packet counters PKT_CNT_A / PKT_CNT_B.
module mux2_rr_arbiter (
   input  logic                     CLK,
   input  logic                     RST,
   mux2_rr_arbiter_if.master        bus
`ifdef MUX2_ARB_STATS_EN
   ,
   output logic [15:0]              PKT_CNT_A,
   output logic [15:0]              PKT_CNT_B
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } state_e;

   state_e state_q, state_d;
   logic   sel_q, sel_d;
   logic   prio_q, prio_d;   // 0: A wins a tie, 1: B wins a tie
   logic   a_fire, b_fire;

   // Beat transfer qualifiers; reset blocks every handshake.
   assign a_fire = (state_q == GRANT_A) & bus.A_VALID & bus.OUT_READY & ~RST;
   assign b_fire = (state_q == GRANT_B) & bus.B_VALID & bus.OUT_READY & ~RST;

   // Datapath mux and handshake outputs decoded from the registered grant.
   always_comb begin
      bus.OUT_VALID = 1'b0;
      bus.A_READY   = 1'b0;
      bus.B_READY   = 1'b0;
      bus.OUT_DATA  = sel_q ? bus.B_DATA : bus.A_DATA;
      bus.OUT_LAST  = sel_q ? bus.B_LAST : bus.A_LAST;
      bus.SEL       = sel_q;
      bus.BUSY      = (state_q == GRANT_A) || (state_q == GRANT_B);
      case (state_q)
         GRANT_A: begin
            bus.OUT_VALID = bus.A_VALID & ~RST;
            bus.A_READY   = bus.OUT_READY & ~RST;
         end
         GRANT_B: begin
            bus.OUT_VALID = bus.B_VALID & ~RST;
            bus.B_READY   = bus.OUT_READY & ~RST;
         end
         default: ;
      endcase
   end

   // Grant selection; a grant is released only by its LAST beat, and the
   // other side is picked up in the same cycle if it is already waiting.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      prio_d  = prio_q;
      case (state_q)
         IDLE: begin
            if (bus.A_VALID && (!bus.B_VALID || !prio_q)) begin
               state_d = GRANT_A;
               sel_d   = 1'b0;
            end else if (bus.B_VALID) begin
               state_d = GRANT_B;
               sel_d   = 1'b1;
            end
         end
         GRANT_A: begin
            if (a_fire && bus.A_LAST) begin
               prio_d = 1'b1;
               if (bus.B_VALID) begin
                  state_d = GRANT_B;
                  sel_d   = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         GRANT_B: begin
            if (b_fire && bus.B_LAST) begin
               prio_d = 1'b0;
               if (bus.A_VALID) begin
                  state_d = GRANT_A;
                  sel_d   = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Grant state, select and priority registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         sel_q   <= 1'b0;
         prio_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         prio_q  <= prio_d;
      end
   end

`ifdef MUX2_ARB_STATS_EN
   logic [15:0] cnt_a_q, cnt_a_d;
   logic [15:0] cnt_b_q, cnt_b_d;

   // Saturating completed-packet counts, bumped on each LAST transfer.
   always_comb begin
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      if (a_fire && bus.A_LAST && (cnt_a_q != 16'hFFFF)) cnt_a_d = cnt_a_q + 16'd1;
      if (b_fire && bus.B_LAST && (cnt_b_q != 16'hFFFF)) cnt_b_d = cnt_b_q + 16'd1;
   end

   // Counter registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_a_q <= 16'd0;
         cnt_b_q <= 16'd0;
      end else begin
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
      end
   end

   assign PKT_CNT_A = cnt_a_q;
   assign PKT_CNT_B = cnt_b_q;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: sources feed beats from queues,
// expected output beats are queued in arbitration order when stimulus is
// created and popped by a monitor on every output transfer.
module tb_mux2_rr_arbiter;
   localparam int SIZE = 8;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   mux2_rr_arbiter_if #(.SIZE(SIZE)) bus();

`ifdef MUX2_ARB_STATS_EN
   logic [15:0] PKT_CNT_A, PKT_CNT_B;
   mux2_rr_arbiter dut (.CLK(CLK), .RST(RST), .bus(bus),
                        .PKT_CNT_A(PKT_CNT_A), .PKT_CNT_B(PKT_CNT_B));
`else
   mux2_rr_arbiter dut (.CLK(CLK), .RST(RST), .bus(bus));
`endif

   typedef struct {logic [7:0] d; logic last; int gap;} beat_t;
   typedef struct {logic [7:0] d; logic last; logic sel;} exp_t;

   beat_t a_src[$];
   beat_t b_src[$];
   exp_t  exp_q[$];
   int    xfer_cyc[$];
   int    cyc = 0;
   int    n_tests = 0;
   int    n_fail = 0;
   bit    xa, xb;
   int    a_hold = 0, b_hold = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(negedge CLK); #3;
   endtask

   task automatic beat(bit src, logic [7:0] d, bit last, int gap = 0, bit ex = 1);
      beat_t b;
      exp_t  e;
      b.d = d; b.last = last; b.gap = gap;
      if (src) b_src.push_back(b); else a_src.push_back(b);
      if (ex) begin
         e.d = d; e.last = last; e.sel = src;
         exp_q.push_back(e);
      end
   endtask

   task automatic drain(string tag, int budget);
      int n = 0;
      while ((exp_q.size() > 0 || a_src.size() > 0 || b_src.size() > 0) && n < budget) begin
         tick(); n++;
      end
      chk({tag, "_drain"}, (exp_q.size() == 0 && a_src.size() == 0 && b_src.size() == 0), 1);
      exp_q.delete(); a_src.delete(); b_src.delete();
      tick();
   endtask

   task automatic do_reset();
      RST = 1'b1; tick(); RST = 1'b0;
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   // Source A: present the head beat, pop it after a handshake.
   initial begin
      bus.A_VALID = 1'b0; bus.A_DATA = '0; bus.A_LAST = 1'b0;
      forever begin
         @(negedge CLK); #4;
         xa = bus.A_VALID && bus.A_READY;
         @(posedge CLK); #1;
         if (xa && a_src.size() > 0) begin a_hold = a_src[0].gap; void'(a_src.pop_front()); end
         if (a_hold > 0) begin bus.A_VALID = 1'b0; a_hold--; end
         else if (a_src.size() > 0) begin
            bus.A_VALID = 1'b1; bus.A_DATA = a_src[0].d; bus.A_LAST = a_src[0].last;
         end else bus.A_VALID = 1'b0;
      end
   end

   // Source B.
   initial begin
      bus.B_VALID = 1'b0; bus.B_DATA = '0; bus.B_LAST = 1'b0;
      forever begin
         @(negedge CLK); #4;
         xb = bus.B_VALID && bus.B_READY;
         @(posedge CLK); #1;
         if (xb && b_src.size() > 0) begin b_hold = b_src[0].gap; void'(b_src.pop_front()); end
         if (b_hold > 0) begin bus.B_VALID = 1'b0; b_hold--; end
         else if (b_src.size() > 0) begin
            bus.B_VALID = 1'b1; bus.B_DATA = b_src[0].d; bus.B_LAST = b_src[0].last;
         end else bus.B_VALID = 1'b0;
      end
   end

   // Monitor: score every output transfer; no handshake during reset.
   initial begin
      forever begin
         @(negedge CLK); #4;
         if (RST) begin
            chk("rst_out_valid", bus.OUT_VALID, 0);
            chk("rst_a_ready", bus.A_READY, 0);
            chk("rst_b_ready", bus.B_READY, 0);
         end else if (bus.OUT_VALID && bus.OUT_READY) begin
            if (exp_q.size() == 0) chk("unexpected_xfer", {24'd0, bus.OUT_DATA}, 32'hDEAD);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("out_data", bus.OUT_DATA, e.d);
               chk("out_last", bus.OUT_LAST, e.last);
               chk("sel", bus.SEL, e.sel);
               chk("a_ready", bus.A_READY, !e.sel);
               chk("b_ready", bus.B_READY, e.sel);
            end
            xfer_cyc.push_back(cyc);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int n;
      bus.OUT_READY = 1'b1;
      tick(); tick();
      RST = 1'b0;
      // Reset state
      chk("rst_sel", bus.SEL, 0);
      chk("rst_busy", bus.BUSY, 0);
      chk("rst_prio", dut.prio_q, 0);
      chk("idle_out_valid", bus.OUT_VALID, 0);
`ifdef MUX2_ARB_STATS_EN
      chk("rst_cnt_a", PKT_CNT_A, 0);
      chk("rst_cnt_b", PKT_CNT_B, 0);
`endif

      // Single requester, 3-beat A packet
      beat(0, 8'h11, 0); beat(0, 8'h22, 0); beat(0, 8'h33, 1);
      drain("single_a", 30);
      chk("single_a_busy", bus.BUSY, 0);
      chk("single_a_sel", bus.SEL, 0);

      // Simultaneous requests from reset: A first, B back-to-back
      do_reset();
      xfer_cyc.delete();
      beat(0, 8'hA0, 0); beat(0, 8'hA1, 1);
      beat(1, 8'hB0, 0); beat(1, 8'hB1, 1);
      drain("simul", 30);
      chk("simul_n", xfer_cyc.size(), 4);
      if (xfer_cyc.size() == 4) chk("simul_no_bubble", xfer_cyc[3] - xfer_cyc[0], 3);
      chk("simul_prio", dut.prio_q, 0);
      chk("simul_sel_held", bus.SEL, 1);

      // Round-robin fairness with single-beat packets
      xfer_cyc.delete();
      for (int i = 0; i < 4; i++) begin beat(0, 8'hAA, 1); beat(1, 8'hBB, 1); end
      drain("rr", 40);
      chk("rr_n", xfer_cyc.size(), 8);
      if (xfer_cyc.size() == 8) chk("rr_rate", xfer_cyc[7] - xfer_cyc[0], 7);

      // Backpressure and source gap during a B packet with A waiting
      beat(1, 8'hC0, 0); beat(1, 8'hC1, 0, 2); beat(1, 8'hC2, 0); beat(1, 8'hC3, 1);
      n = 0;
      while (!(bus.BUSY && bus.SEL) && n < 10) begin tick(); n++; end
      chk("bp_grant_b", bus.BUSY && bus.SEL, 1);
      beat(0, 8'hA5, 1);
      for (int i = 0; i < 4; i++) begin
         bus.OUT_READY = pat[i];
         tick();
         chk("bp_sel", bus.SEL, 1);
         chk("bp_a_ready", bus.A_READY, 0);
      end
      bus.OUT_READY = 1'b1;
      n = 0;
      while (b_src.size() > 0 && n < 20) begin
         chk("bp_sel_gap", bus.SEL, 1);
         chk("bp_a_ready_gap", bus.A_READY, 0);
         tick(); n++;
      end
      drain("bp", 30);
      chk("bp_prio", dut.prio_q, 1);

      // Reset after beat 2 of a 4-beat A packet, B waiting
      for (int i = 0; i < 4; i++) beat(0, 8'hE0 + 8'(i), (i == 3));
      n = 0;
      while (!(bus.BUSY && !bus.SEL) && n < 10) begin tick(); n++; end
      beat(1, 8'hD1, 1, 0, 0);
      xfer_cyc.delete();
      n = 0;
      while (xfer_cyc.size() < 2 && n < 20) begin tick(); n++; end
      chk("mid_two_beats", xfer_cyc.size(), 2);
      RST = 1'b1;
      a_src.delete(); exp_q.delete();
      beat(1, 8'hD1, 1, 0, 0);
      void'(b_src.pop_back());
      begin
         exp_t e;
         e.d = 8'hD1; e.last = 1'b1; e.sel = 1'b1;
         exp_q.push_back(e);
      end
      tick();
      RST = 1'b0;
      chk("mid_idle", bus.BUSY, 0);
      chk("mid_sel", bus.SEL, 0);
      chk("mid_prio", dut.prio_q, 0);
      tick();
      chk("mid_grant_b", {bus.BUSY, bus.SEL}, 2'b11);
      drain("mid", 20);
      chk("mid_n", xfer_cyc.size(), 3);

`ifdef MUX2_ARB_STATS_EN
      // Packet counters and saturation
      do_reset();
      beat(0, 8'h31, 1); beat(1, 8'h41, 0); beat(1, 8'h42, 1);
      beat(0, 8'h32, 1); beat(1, 8'h43, 1); beat(0, 8'h33, 1);
      drain("stats", 40);
      chk("cnt_a", PKT_CNT_A, 3);
      chk("cnt_b", PKT_CNT_B, 2);
      dut.cnt_a_q = 16'hFFFE;
      tick();
      beat(0, 8'h51, 1);
      drain("stats_sat1", 20);
      chk("cnt_a_ffff", PKT_CNT_A, 16'hFFFF);
      beat(0, 8'h52, 0); beat(0, 8'h53, 1);
      drain("stats_sat2", 20);
      chk("cnt_a_sat", PKT_CNT_A, 16'hFFFF);
      chk("cnt_b_keep", PKT_CNT_B, 2);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
